// File: rtl/ldt_rx_deser_align.sv
// ---------------------------------------------------------------------------
// ldt_rx_deser_align
//
// Serial-to-parallel deserializer with frame alignment for the LDT receive
// path. The single-ended data bit from the differential input buffer is
// shifted in MSB first on every CE-qualified clock. The block hunts for
// SYNC_PATTERN with a sliding compare. It then verifies the pattern on word
// boundaries until LOCK_CNT consecutive aligned hits have been seen. After
// that it emits WIDTH-bit words with a one-cycle valid strobe.
//
// Ports
//   C       in   1      clock, all state changes on the rising edge
//   R       in   1      synchronous active-high reset
//   CE      in   1      bit enable; D is sampled only when CE=1
//   D       in   1      serial data bit
//   RESYNC  in   1      synchronous request to drop lock and re-hunt
//   Q       out  WIDTH  last completed aligned word, MSB = first bit received
//   QV      out  1      one-cycle strobe, Q updated this cycle
//   QS      out  1      qualifies QV, Q equals SYNC_PATTERN
//   LOCKED  out  1      high while aligned
// ---------------------------------------------------------------------------
module ldt_rx_deser_align #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(8'hA5),
    parameter int               LOCK_CNT     = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic             D,
    input  logic             RESYNC,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             QS,
    output logic             LOCKED
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]     LOCK_N   = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        VERIFY  = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qv_q, qv_d;
    logic             qs_q, qs_d;
    logic             locked_q, locked_d;

    // Shift register contents as they will be after this bit is taken.
    // All pattern compares use this value so that a hit is seen on the same
    // edge that samples the final bit.
    logic [WIDTH-1:0] nxt;
    logic             word_end;
    logic             is_sync;
    logic [3:0]       match_inc;

    always_comb begin
        nxt       = {sr_q[WIDTH-2:0], D};
        word_end  = (bit_cnt_q == LAST_BIT);
        is_sync   = (nxt == SYNC_PATTERN);
        match_inc = match_cnt_q + 4'd1;

        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        q_d         = q_q;
        qv_d        = 1'b0;
        qs_d        = qs_q;
        locked_d    = locked_q;

        if (RESYNC) begin
            // The partial word is dropped. Q and the shift register are kept.
            state_d     = HUNT;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
            locked_d    = 1'b0;
            qs_d        = 1'b0;
        end else if (CE) begin
            sr_d = nxt;
            case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        state_d     = VERIFY;
                        bit_cnt_d   = '0;
                        match_cnt_d = 4'd1;
                    end
                end
                VERIFY: begin
                    if (word_end) begin
                        bit_cnt_d = '0;
                        if (is_sync) begin
                            match_cnt_d = match_inc;
                            if (match_inc == LOCK_N) begin
                                state_d  = ALIGNED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            // The failed word is not rescanned. The sliding
                            // search resumes with the next bit.
                            state_d     = HUNT;
                            match_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ALIGNED: begin
                    if (word_end) begin
                        bit_cnt_d = '0;
                        q_d       = nxt;
                        qv_d      = 1'b1;
                        qs_d      = is_sync;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = HUNT;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            q_q         <= '0;
            qv_q        <= 1'b0;
            qs_q        <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            q_q         <= q_d;
            qv_q        <= qv_d;
            qs_q        <= qs_d;
            locked_q    <= locked_d;
        end
    end

    assign Q      = q_q;
    assign QV     = qv_q;
    assign QS     = qs_q;
    assign LOCKED = locked_q;

endmodule

// File: tb/tb_ldt_rx_deser_align.sv
// ---------------------------------------------------------------------------
// tb_ldt_rx_deser_align
//
// Directed bench for ldt_rx_deser_align (WIDTH=8, SYNC=8'hA5, LOCK_CNT=4).
// Words are shifted in MSB first. Outputs are sampled 1 time unit after the
// rising edge. One line is printed per word sent.
// ---------------------------------------------------------------------------
module tb_ldt_rx_deser_align;

    logic       C;
    logic       R;
    logic       CE;
    logic       D;
    logic       RESYNC;
    logic [7:0] Q;
    logic       QV;
    logic       QS;
    logic       LOCKED;

    int n_checks = 0;
    int n_errors = 0;

    ldt_rx_deser_align #(
        .WIDTH       (8),
        .SYNC_PATTERN(8'hA5),
        .LOCK_CNT    (4)
    ) dut (
        .C     (C),
        .R     (R),
        .CE    (CE),
        .D     (D),
        .RESYNC(RESYNC),
        .Q     (Q),
        .QV    (QV),
        .QS    (QS),
        .LOCKED(LOCKED)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Send bits w[hi] down to w[lo] with CE=1 and count QV strobes seen.
    task automatic send_bits(input logic [7:0] w, input int hi, input int lo, output int qv_cnt);
        qv_cnt = 0;
        for (int i = hi; i >= lo; i--) begin
            D  = w[i];
            CE = 1'b1;
            tick();
            if (QV) qv_cnt++;
        end
    endtask

    // Send a full word. No QV is allowed before the last bit. After the last
    // bit QV must equal exp_qv and, when a strobe is expected, Q and QS too.
    task automatic send_word(input string tag, input logic [7:0] w, input logic exp_qv,
                             input logic [7:0] exp_q, input logic exp_qs);
        int early;
        int last;
        send_bits(w, 7, 1, early);
        send_bits(w, 0, 0, last);
        $display("word %h: qv=%b q=%h qs=%b locked=%b (%s)", w, QV, Q, QS, LOCKED, tag);
        check({tag, "_early_qv"}, early, 0);
        check({tag, "_qv"}, QV, exp_qv);
        if (exp_qv) begin
            check({tag, "_q"}, Q, exp_q);
            check({tag, "_qs"}, QS, exp_qs);
        end
    endtask

    task automatic do_reset(input int cycles);
        R = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            D = 1'($urandom_range(0, 1));
            tick();
        end
        R = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_q"}, Q, 8'h00);
        check({tag, "_qv"}, QV, 0);
        check({tag, "_qs"}, QS, 0);
        check({tag, "_locked"}, LOCKED, 0);
    endtask

    int cnt;

    initial begin
        R      = 1'b1;
        CE     = 1'b0;
        D      = 1'b0;
        RESYNC = 1'b0;

        // 1. Reset, then a long run of zeros must not lock.
        do_reset(2);
        check_reset_vals("t1_reset");
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            int c;
            send_bits(8'h00, 0, 0, c);
            cnt += c;
        end
        $display("zeros x64: locked=%b qv_count=%0d", LOCKED, cnt);
        check("t1_zero_qv", cnt, 0);
        check("t1_zero_locked", LOCKED, 0);

        // 2. Three junk bits, 4x A5 to lock, then a data word.
        send_bits(8'h02, 2, 0, cnt);
        check("t2_junk_qv", cnt, 0);
        for (int i = 0; i < 4; i++) begin
            send_word("t2_sync", 8'hA5, 1'b0, 8'h00, 1'b0);
            check("t2_lock_state", LOCKED, (i == 3) ? 1 : 0);
        end
        send_word("t2_data", 8'h3C, 1'b1, 8'h3C, 1'b0);
        send_bits(8'h00, 0, 0, cnt);
        check("t2_qv_one_cycle", QV, 0);
        check("t2_q_hold", Q, 8'h3C);

        // 3. A broken verify sequence must not lock. A clean run of 4 then locks.
        do_reset(1);
        send_word("t3_a", 8'hA5, 1'b0, 8'h00, 1'b0);
        send_word("t3_b", 8'hA5, 1'b0, 8'h00, 1'b0);
        send_word("t3_zero", 8'h00, 1'b0, 8'h00, 1'b0);
        check("t3_no_lock_after_00", LOCKED, 0);
        for (int i = 0; i < 4; i++) begin
            send_word("t3_sync", 8'hA5, 1'b0, 8'h00, 1'b0);
            check("t3_lock_state", LOCKED, (i == 3) ? 1 : 0);
        end
        send_word("t3_sync_data", 8'hA5, 1'b1, 8'hA5, 1'b1);

        // 4. CE low mid-word with D toggling: word preserved, no strobe.
        send_bits(8'h5C, 7, 4, cnt);
        check("t4_pre_qv", cnt, 0);
        cnt = 0;
        CE  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            D = i[0];
            tick();
            if (QV) cnt++;
        end
        check("t4_ce_low_qv", cnt, 0);
        check("t4_ce_low_q", Q, 8'hA5);
        send_bits(8'h5C, 3, 1, cnt);
        check("t4_resume_qv", cnt, 0);
        send_bits(8'h5C, 0, 0, cnt);
        $display("word 5c (ce gap): qv=%b q=%h qs=%b locked=%b", QV, Q, QS, LOCKED);
        check("t4_qv", QV, 1);
        check("t4_q", Q, 8'h5C);
        check("t4_qs", QS, 0);

        // 5. RESYNC after bit 3: lock drops, Q holds, relock needs 4x A5.
        send_bits(8'h00, 7, 5, cnt);
        RESYNC = 1'b1;
        D      = 1'b0;
        tick();
        RESYNC = 1'b0;
        $display("resync: qv=%b q=%h qs=%b locked=%b", QV, Q, QS, LOCKED);
        check("t5_locked", LOCKED, 0);
        check("t5_qv", QV, 0);
        check("t5_q_hold", Q, 8'h5C);
        send_bits(8'h00, 4, 0, cnt);
        check("t5_partial_qv", cnt, 0);
        for (int i = 0; i < 4; i++) begin
            send_word("t5_sync", 8'hA5, 1'b0, 8'h00, 1'b0);
            check("t5_relock_state", LOCKED, (i == 3) ? 1 : 0);
        end
        send_word("t5_data", 8'hC3, 1'b1, 8'hC3, 1'b0);

        // 6. Reset during VERIFY after two matches clears the match count.
        do_reset(1);
        send_word("t6_a", 8'hA5, 1'b0, 8'h00, 1'b0);
        send_word("t6_b", 8'hA5, 1'b0, 8'h00, 1'b0);
        do_reset(1);
        check_reset_vals("t6_reset");
        for (int i = 0; i < 4; i++) begin
            send_word("t6_sync", 8'hA5, 1'b0, 8'h00, 1'b0);
            check("t6_lock_state", LOCKED, (i == 3) ? 1 : 0);
        end
        send_word("t6_data", 8'h96, 1'b1, 8'h96, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
